// File: rtl/ai_pilot_pkg.sv
// dino_ai_pkg: shared definitions for the Dino autopilot.
//   - 3-bit FSM state encoding (localparams plus matching enum type)
//   - CNT_W: width of the hold/delay down-counters
//   - pos_w(): x-position width after dropping CONV LSBs
package dino_ai_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] S_RUN        = 3'd0;
  localparam logic [2:0] S_JUMP       = 3'd1;
  localparam logic [2:0] S_DUCK       = 3'd2;
  localparam logic [2:0] S_CRASH_WAIT = 3'd3;
  localparam logic [2:0] S_RESTART    = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN        = S_RUN,
    ST_JUMP       = S_JUMP,
    ST_DUCK       = S_DUCK,
    ST_CRASH_WAIT = S_CRASH_WAIT,
    ST_RESTART    = S_RESTART
  } ai_state_e;

  function automatic int pos_w(input int conv);
    return 10 - conv;
  endfunction

endpackage

// File: rtl/ai_pilot_if.sv
// ai_pilot_if: bundle between gamepad/game FSM and the autopilot.
//   master : game side (drives gamepad, obstacles, crash/frozen; reads buttons)
//   slave  : ai_pilot (reads inputs; drives buttons, ai_active[, crash_count])
//   crash_count exists only when AI_STATS_EN is defined.
interface ai_pilot_if #(
  parameter int NUM_OBS = 2,
  parameter int POS_W   = 10
);
  logic                     gamepad_is_present;
  logic                     gamepad_start;
  logic                     gamepad_up;
  logic                     gamepad_down;
  logic [NUM_OBS*POS_W-1:0] obstacle_pos;
  logic [NUM_OBS-1:0]       obstacle_is_bird;
  logic                     crash;
  logic                     game_frozen;
  logic                     button_start;
  logic                     button_up;
  logic                     button_down;
  logic                     ai_active;
`ifdef AI_STATS_EN
  logic [7:0]               crash_count;

  modport master (
    output gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    output obstacle_pos, obstacle_is_bird, crash, game_frozen,
    input  button_start, button_up, button_down, ai_active, crash_count
  );
  modport slave (
    input  gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    input  obstacle_pos, obstacle_is_bird, crash, game_frozen,
    output button_start, button_up, button_down, ai_active, crash_count
  );
`else
  modport master (
    output gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    output obstacle_pos, obstacle_is_bird, crash, game_frozen,
    input  button_start, button_up, button_down, ai_active
  );
  modport slave (
    input  gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    input  obstacle_pos, obstacle_is_bird, crash, game_frozen,
    output button_start, button_up, button_down, ai_active
  );
`endif
endinterface

// File: rtl/ai_pilot_nearest_obstacle.sv
// ai_nearest_obstacle: combinational pick of the nearest valid obstacle.
//   in : obstacle_pos (NUM_OBS packed POS_W fields), obstacle_is_bird
//   out: target_valid, target_pos, target_is_bird
// A channel is valid when PLAYER_OFFSET < pos < GEN_LINE. Ties on pos go
// to the lowest index, except that a ground obstacle beats a bird.
module ai_nearest_obstacle #(
  parameter int NUM_OBS       = 2,
  parameter int POS_W         = 10,
  parameter int PLAYER_OFFSET = 6,
  parameter int GEN_LINE      = 250
) (
  input  logic [NUM_OBS*POS_W-1:0] obstacle_pos,
  input  logic [NUM_OBS-1:0]       obstacle_is_bird,
  output logic                     target_valid,
  output logic [POS_W-1:0]         target_pos,
  output logic                     target_is_bird
);

  localparam logic [POS_W-1:0] OFF_P = POS_W'(PLAYER_OFFSET);
  localparam logic [POS_W-1:0] GEN_P = POS_W'(GEN_LINE);

  logic [POS_W-1:0] p;
  logic             b;

  always_comb begin
    target_valid   = 1'b0;
    target_pos     = '0;
    target_is_bird = 1'b0;
    p              = '0;
    b              = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      p = obstacle_pos[i*POS_W +: POS_W];
      b = obstacle_is_bird[i];
      if (p > OFF_P && p < GEN_P) begin
        // strict '<' keeps the lower index on a tie; ground displaces a bird
        if (!target_valid || p < target_pos ||
            (p == target_pos && target_is_bird && !b)) begin
          target_valid   = 1'b1;
          target_pos     = p;
          target_is_bird = b;
        end
      end
    end
  end

endmodule

// File: rtl/ai_pilot.sv
// ai_pilot: autonomous Dino player with gamepad pass-through.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : gamepad buttons, obstacle positions/types, crash and
//                  game_frozen in; registered button_start/up/down and
//                  ai_active out. With AI_STATS_EN defined, bus also carries
//                  crash_count, a saturating count of crash-caused entries
//                  into CRASH_WAIT (cleared by rst only).
//
// state      | meaning
// RUN        | no buttons; watch for crash/frozen, jump or duck target
// JUMP       | button_up held for JUMP_HOLD cycles
// DUCK       | button_down while a bird target stays within DUCK_THRESH
// CRASH_WAIT | idle RESTART_DELAY cycles, crash/frozen ignored
// RESTART    | button_start for START_PULSE cycles, then RUN or retry
module ai_pilot
  import dino_ai_pkg::*;
#(
  parameter int CONV          = 0,
  parameter int NUM_OBS       = 2,
  parameter int PLAYER_OFFSET = 6,
  parameter int GEN_LINE      = 250,
  parameter int JUMP_THRESH   = 30,
  parameter int DUCK_THRESH   = 40,
  parameter int JUMP_HOLD     = 8,
  parameter int RESTART_DELAY = 60,
  parameter int START_PULSE   = 4
) (
  input  logic    clk,
  input  logic    rst,
  ai_pilot_if.slave bus
);

  localparam int               POS_W  = pos_w(CONV);
  localparam logic [POS_W-1:0] JUMP_P = POS_W'(JUMP_THRESH);
  localparam logic [POS_W-1:0] DUCK_P = POS_W'(DUCK_THRESH);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(JUMP_HOLD);
  localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(RESTART_DELAY);
  localparam logic [CNT_W-1:0] PUL_C  = CNT_W'(START_PULSE);

  ai_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_d, up_d, down_d, ai_d;
  logic             tgt_valid, tgt_bird;
  logic [POS_W-1:0] tgt_pos;
  logic             jump_hit, duck_hit;

  ai_nearest_obstacle #(
    .NUM_OBS      (NUM_OBS),
    .POS_W        (POS_W),
    .PLAYER_OFFSET(PLAYER_OFFSET),
    .GEN_LINE     (GEN_LINE)
  ) u_nearest (
    .obstacle_pos    (bus.obstacle_pos),
    .obstacle_is_bird(bus.obstacle_is_bird),
    .target_valid    (tgt_valid),
    .target_pos      (tgt_pos),
    .target_is_bird  (tgt_bird)
  );

  assign jump_hit = tgt_valid && !tgt_bird && (tgt_pos <= JUMP_P);
  assign duck_hit = tgt_valid &&  tgt_bird && (tgt_pos <= DUCK_P);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    ai_d    = 1'b1;
    if (bus.gamepad_is_present) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      start_d = bus.gamepad_start;
      up_d    = bus.gamepad_up;
      down_d  = bus.gamepad_down;
      ai_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.crash || bus.game_frozen) begin
            state_d = ST_CRASH_WAIT;
            cnt_d   = DLY_C;
          end else if (jump_hit) begin
            state_d = ST_JUMP;
            cnt_d   = HOLD_C;
          end else if (duck_hit) begin
            state_d = ST_DUCK;
          end
        end
        ST_JUMP: begin
          if (bus.crash) begin
            state_d = ST_CRASH_WAIT;
            cnt_d   = DLY_C;
          end else if (cnt_q <= 8'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_DUCK: begin
          if (bus.crash) begin
            state_d = ST_CRASH_WAIT;
            cnt_d   = DLY_C;
          end else if (duck_hit) begin
            state_d = ST_DUCK;
          end else if (jump_hit) begin
            state_d = ST_JUMP;
            cnt_d   = HOLD_C;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_CRASH_WAIT: begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_RESTART;
            cnt_d   = PUL_C;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RESTART: begin
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else if (bus.crash || bus.game_frozen) begin
            // game still not running: wait and press start again
            state_d = ST_CRASH_WAIT;
            cnt_d   = DLY_C;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
      // buttons follow the state being entered so they are registered with it
      start_d = (state_d == ST_RESTART);
      up_d    = (state_d == ST_JUMP);
      down_d  = (state_d == ST_DUCK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      cnt_q            <= '0;
      bus.button_start <= 1'b0;
      bus.button_up    <= 1'b0;
      bus.button_down  <= 1'b0;
      bus.ai_active    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bus.button_start <= start_d;
      bus.button_up    <= up_d;
      bus.button_down  <= down_d;
      bus.ai_active    <= ai_d;
    end
  end

`ifdef AI_STATS_EN
  logic crash_inc;

  // only crash (not game_frozen) out of an active-play state counts
  assign crash_inc = !bus.gamepad_is_present && bus.crash &&
                     (state_q == ST_RUN || state_q == ST_JUMP || state_q == ST_DUCK) &&
                     (state_d == ST_CRASH_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.crash_count <= '0;
    end else if (crash_inc && bus.crash_count != 8'hFF) begin
      bus.crash_count <= bus.crash_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ai_pilot.sv
// tb_ai_pilot: directed bench for ai_pilot with default parameters.
// Outputs are sampled 1 time unit after each rising edge; inputs are
// changed at the same point so each step sees one-cycle latency.
module tb_ai_pilot;
  import dino_ai_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ai_pilot_if #(.NUM_OBS(2), .POS_W(10)) bus ();

  ai_pilot dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // {start, up, down, ai_active}
  logic [3:0] outs;
  assign outs = {bus.button_start, bus.button_up, bus.button_down, bus.ai_active};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_obs(input logic [9:0] p0, input logic b0,
                         input logic [9:0] p1, input logic b1);
    bus.obstacle_pos     = {p1, p0};
    bus.obstacle_is_bird = {b1, b0};
  endtask

  initial begin
    bus.gamepad_is_present = 1'b0;
    bus.gamepad_start      = 1'b0;
    bus.gamepad_up         = 1'b0;
    bus.gamepad_down       = 1'b0;
    bus.crash              = 1'b0;
    bus.game_frozen        = 1'b0;
    set_obs(10'd0, 1'b0, 10'd0, 1'b0);

    // reset
    #1 rst = 1'b1;
    #1 chk("reset_outs", {4'h0, outs}, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_run", {4'h0, outs}, 8'h01);

    // jump: 31 does not trigger, 30 does; up held exactly 8 cycles
    set_obs(10'd31, 1'b0, 10'd0, 1'b0);
    tick();
    chk("jump_pos31_none", {4'h0, outs}, 8'h01);
    set_obs(10'd30, 1'b0, 10'd0, 1'b0);
    tick();
    chk("jump_pos30_up", {4'h0, outs}, 8'h05);
    set_obs(10'd0, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("jump_hold", {4'h0, outs}, 8'h05);
    end
    tick();
    chk("jump_release", {4'h0, outs}, 8'h01);
    set_obs(10'd6, 1'b0, 10'd0, 1'b0);
    tick();
    chk("jump_pos6_none", {4'h0, outs}, 8'h01);
    tick();
    chk("jump_pos6_none2", {4'h0, outs}, 8'h01);

    // reset mid-jump aborts asynchronously
    set_obs(10'd20, 1'b0, 10'd0, 1'b0);
    tick();
    chk("midjump_up", {4'h0, outs}, 8'h05);
    tick();
    set_obs(10'd0, 1'b0, 10'd0, 1'b0);
    rst = 1'b1;
    #1 chk("midjump_async_rst", {4'h0, outs}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("midjump_run_after", {4'h0, outs}, 8'h01);
    tick();
    chk("midjump_run_after2", {4'h0, outs}, 8'h01);

    // duck on ch1 bird
    set_obs(10'd0, 1'b0, 10'd40, 1'b1);
    tick();
    chk("duck_pos40", {4'h0, outs}, 8'h03);
    tick();
    chk("duck_hold", {4'h0, outs}, 8'h03);
    set_obs(10'd0, 1'b0, 10'd6, 1'b1);
    tick();
    chk("duck_release", {4'h0, outs}, 8'h01);
    set_obs(10'd0, 1'b0, 10'd41, 1'b1);
    tick();
    chk("duck_pos41_none", {4'h0, outs}, 8'h01);

    // priority: ground beats bird on equal pos
    set_obs(10'd20, 1'b1, 10'd20, 1'b0);
    tick();
    chk("tie_ground_wins", {4'h0, outs}, 8'h05);
    set_obs(10'd0, 1'b0, 10'd0, 1'b0);
    repeat (8) tick();
    chk("tie_jump_done", {4'h0, outs}, 8'h01);

    // nearer bird ducks, then jump once ground is nearest
    set_obs(10'd25, 1'b0, 10'd10, 1'b1);
    tick();
    chk("near_bird_duck", {4'h0, outs}, 8'h03);
    set_obs(10'd25, 1'b0, 10'd6, 1'b1);
    tick();
    chk("duck_to_jump", {4'h0, outs}, 8'h05);
    set_obs(10'd0, 1'b0, 10'd0, 1'b0);
    repeat (8) tick();
    chk("duck_jump_done", {4'h0, outs}, 8'h01);

    // restart after a single-cycle crash
    bus.crash = 1'b1;
    tick();
    bus.crash = 1'b0;
    chk("crash_wait_enter", {4'h0, outs}, 8'h01);
    for (int i = 0; i < 59; i++) begin
      tick();
      chk("crash_wait_quiet", {4'h0, outs}, 8'h01);
    end
    tick();
    chk("restart_pulse0", {4'h0, outs}, 8'h09);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("restart_pulse", {4'h0, outs}, 8'h09);
    end
    tick();
    chk("restart_to_run", {4'h0, outs}, 8'h01);
`ifdef AI_STATS_EN
    chk("crash_count_1", bus.crash_count, 8'd1);
`endif

    // crash held: retry loop
    bus.crash = 1'b1;
    tick();
    chk("retry_enter", {4'h0, outs}, 8'h01);
    repeat (59) tick();
    chk("retry_wait_end", {4'h0, outs}, 8'h01);
    tick();
    chk("retry_pulse1", {4'h0, outs}, 8'h09);
    repeat (3) tick();
    chk("retry_pulse1_last", {4'h0, outs}, 8'h09);
    tick();
    chk("retry_back_wait", {4'h0, outs}, 8'h01);
    repeat (59) tick();
    chk("retry_wait2_end", {4'h0, outs}, 8'h01);
    tick();
    chk("retry_pulse2", {4'h0, outs}, 8'h09);
    bus.crash = 1'b0;
    repeat (3) tick();
    tick();
    chk("retry_to_run", {4'h0, outs}, 8'h01);
`ifdef AI_STATS_EN
    chk("crash_count_2", bus.crash_count, 8'd2);
`endif

    // game_frozen also restarts but is not counted as a crash
    bus.game_frozen = 1'b1;
    tick();
    bus.game_frozen = 1'b0;
    repeat (59) tick();
    chk("frozen_wait_end", {4'h0, outs}, 8'h01);
    tick();
    chk("frozen_pulse", {4'h0, outs}, 8'h09);
    repeat (3) tick();
    tick();
    chk("frozen_to_run", {4'h0, outs}, 8'h01);
`ifdef AI_STATS_EN
    chk("crash_count_frozen", bus.crash_count, 8'd2);
`endif

    // override during CRASH_WAIT
    bus.crash = 1'b1;
    tick();
    bus.crash = 1'b0;
    repeat (5) tick();
    bus.gamepad_is_present = 1'b1;
    bus.gamepad_start      = 1'b1;
    bus.gamepad_up         = 1'b1;
    tick();
    chk("override_mirror1", {4'h0, outs}, 8'h0C);
    bus.gamepad_start = 1'b0;
    bus.gamepad_up    = 1'b0;
    bus.gamepad_down  = 1'b1;
    tick();
    chk("override_mirror2", {4'h0, outs}, 8'h02);
    bus.gamepad_is_present = 1'b0;
    bus.gamepad_down       = 1'b0;
    tick();
    chk("override_release_run", {4'h0, outs}, 8'h01);
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("override_no_restart", {4'h0, outs}, 8'h01);
    end
`ifdef AI_STATS_EN
    chk("crash_count_3", bus.crash_count, 8'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
